bit_skip_sequencer: RTL and testbench



---
 rtl/bitsim_seq_pkg.sv | 20 ++
 rtl/p_encoder_comb.sv | 36 +++
 rtl/bit_skip_sequencer.sv | 115 +++++++++++
 tb/tb_bit_skip_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitsim_seq_pkg.sv
// ============================================================================
// Module : bitsim_seq_pkg
// Brief  : Shared state encoding and default sizes for the bit-skip sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bitsim_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_IDX_W = $clog2(DEFAULT_WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/p_encoder_comb.sv
// ============================================================================
// Module : p_encoder_comb
// Brief  : Combinational leading-one encoder, MSB-relative (bit W-1 -> 0).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module p_encoder_comb #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             is_zero,
  output logic             is_onehot
);

  logic [IDX_W:0] ones;

  // Ascending scan: the last set bit seen is the highest one, so it wins.
  always_comb begin
    idx  = '0;
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) begin
        idx  = IDX_W'(WIDTH - 1 - i);
        ones = ones + {{IDX_W{1'b0}}, 1'b1};
      end
    end
    is_zero   = (mask == '0);
    is_onehot = (ones == {{IDX_W{1'b0}}, 1'b1});
  end

endmodule

`default_nettype wire

// File: rtl/bit_skip_sequencer.sv
// ============================================================================
// Module : bit_skip_sequencer
// Brief  : Walks the set bits of a mask MSB-first, one index per output beat.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bit_skip_sequencer
  import bitsim_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty,
  output logic [IDX_W:0]   out_beat
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             empty_q, empty_d;
  logic [IDX_W:0]   beat_q, beat_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_zero;
  logic             enc_onehot;
  logic [WIDTH-1:0] clr_onehot;
  logic             in_fire;
  logic             out_fire;

  p_encoder_comb #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .mask      (mask_q),
    .idx       (enc_idx),
    .is_zero   (enc_zero),
    .is_onehot (enc_onehot)
  );

  assign out_valid = (state_q == RUN);
  assign out_fire  = out_valid & out_ready;
  assign out_last  = empty_q | enc_onehot;
  assign out_empty = empty_q;
  assign out_beat  = beat_q;
  assign out_idx   = (empty_q | enc_zero) ? '0 : enc_idx;
  // Accepting on the final beat lets the next mask follow with no bubble.
  assign in_ready  = (state_q == IDLE) | (out_fire & out_last);
  assign in_fire   = in_valid & in_ready;

  always_comb begin
    clr_onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      clr_onehot[i] = (enc_idx == IDX_W'(WIDTH - 1 - i));
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    empty_d = empty_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d = RUN;
          mask_d  = in_mask;
          empty_d = (in_mask == '0);
          beat_d  = '0;
        end
      end
      RUN: begin
        if (out_fire) begin
          if (!out_last) begin
            mask_d = mask_q & ~clr_onehot;
            beat_d = beat_q + {{IDX_W{1'b0}}, 1'b1};
          end else if (in_fire) begin
            mask_d  = in_mask;
            empty_d = (in_mask == '0);
            beat_d  = '0;
          end else begin
            state_d = IDLE;
            mask_d  = '0;
            empty_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      empty_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      empty_q <= empty_d;
      beat_q  <= beat_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_skip_sequencer.sv
// ============================================================================
// Module : tb_bit_skip_sequencer
// Brief  : Self-checking bench against a queue-based beat model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bit_skip_sequencer;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_mask = '0;
  logic             in_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_empty;
  logic [IDX_W:0]   out_beat;

  always #5 clk = ~clk;

  bit_skip_sequencer #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_empty (out_empty),
    .out_beat  (out_beat)
  );

  typedef struct {
    int               cyc;
    bit               fired;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             empty;
    logic [IDX_W:0]   beat;
    logic             in_rdy;
  } obs_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             empty;
    logic [IDX_W:0]   beat;
  } exp_t;

  int               checks = 0;
  int               failures = 0;
  obs_t             obs[$];
  exp_t             exp_q[$];
  int               acc[$];
  logic [WIDTH-1:0] pend[$];
  bit               timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beat list: set bits high to low, one beat each; an all-zero
  // mask yields a single beat flagged empty.
  task automatic build_expected();
    int n;
    int total;
    exp_q.delete();
    foreach (pend[m]) begin
      n = 0;
      total = $countones(pend[m]);
      if (total == 0)
        exp_q.push_back('{idx: '0, last: 1'b1, empty: 1'b1, beat: '0});
      for (int p = WIDTH - 1; p >= 0; p--) begin
        if (pend[m][p]) begin
          exp_q.push_back('{idx: IDX_W'(WIDTH - 1 - p), last: (n == total - 1),
                            empty: 1'b0, beat: (IDX_W+1)'(n)});
          n++;
        end
      end
    end
  endtask

  // Drives the pending masks and records every valid cycle; no judging here.
  // mode 0: ready always high, 1: ready 1,0,0 pattern, 2: random ready/valid.
  task automatic drive_stream(input int mode);
    int cyc;
    bit done;
    cyc = 0;
    done = 0;
    obs.delete();
    acc.delete();
    timed_out = 0;
    while (!done) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (pend.size() > 0 && (mode != 2 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_mask  = pend[0];
      end else begin
        in_valid = 1'b0;
        in_mask  = WIDTH'($urandom);
      end
      #1;
      if (out_valid)
        obs.push_back('{cyc: cyc, fired: out_ready, idx: out_idx, last: out_last,
                        empty: out_empty, beat: out_beat, in_rdy: in_ready});
      if (in_valid && in_ready) begin
        acc.push_back(cyc);
        void'(pend.pop_front());
      end else if (pend.size() == 0 && out_valid && out_ready && out_last) begin
        done = 1;
      end
      if (cyc > 3000) begin
        timed_out = 1;
        done = 1;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_idx, out_last, out_empty, out_beat} !==
        {1'b0, 1'b1, {IDX_W{1'b0}}, 1'b0, 1'b0, {(IDX_W+1){1'b0}}}) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b ready=%b idx=%0d last=%b empty=%b beat=%0d, want 0 1 0 0 0 0",
               out_valid, in_ready, out_idx, out_last, out_empty, out_beat);
    end
  endtask

  task automatic test_spaced();
    int n;
    int prev;
    pend = '{16'h8421};
    build_expected();
    drive_stream(0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL spaced_timeout: got timeout, want completion"); end
    n = 0;
    prev = -1;
    foreach (obs[i]) begin
      if (obs[i].fired) begin
        if (n < exp_q.size()) begin
          checks++;
          if ({obs[i].idx, obs[i].last, obs[i].empty, obs[i].beat} !==
              {exp_q[n].idx, exp_q[n].last, exp_q[n].empty, exp_q[n].beat}) begin
            failures++;
            $display("FAIL spaced_beat%0d: got idx=%0d last=%b empty=%b beat=%0d, want idx=%0d last=%b empty=%b beat=%0d",
                     n, obs[i].idx, obs[i].last, obs[i].empty, obs[i].beat,
                     exp_q[n].idx, exp_q[n].last, exp_q[n].empty, exp_q[n].beat);
          end
        end
        checks++;
        if (obs[i].cyc !== ((n == 0) ? acc[0] + 1 : prev + 1)) begin
          failures++;
          $display("FAIL spaced_timing%0d: got cycle %0d, want %0d", n, obs[i].cyc,
                   (n == 0) ? acc[0] + 1 : prev + 1);
        end
        prev = obs[i].cyc;
        n++;
      end
    end
    checks++;
    if (n != exp_q.size()) begin
      failures++;
      $display("FAIL spaced_count: got %0d beats, want %0d", n, exp_q.size());
    end
  endtask

  task automatic test_empty_then_one();
    obs_t f[$];
    pend = '{16'h0000, 16'h0001};
    drive_stream(0);
    foreach (obs[i]) if (obs[i].fired) f.push_back(obs[i]);
    checks++;
    if (timed_out || f.size() != 2) begin
      failures++;
      $display("FAIL empty_count: got %0d beats timeout=%0d, want 2 beats", f.size(), timed_out);
    end else begin
      checks++;
      if ({f[0].idx, f[0].last, f[0].empty, f[0].beat} !== {4'd0, 1'b1, 1'b1, 5'd0}) begin
        failures++;
        $display("FAIL empty_beat: got idx=%0d last=%b empty=%b beat=%0d, want idx=0 last=1 empty=1 beat=0",
                 f[0].idx, f[0].last, f[0].empty, f[0].beat);
      end
      checks++;
      if ({f[1].idx, f[1].last, f[1].empty, f[1].beat} !== {4'd15, 1'b1, 1'b0, 5'd0}) begin
        failures++;
        $display("FAIL one_beat: got idx=%0d last=%b empty=%b beat=%0d, want idx=15 last=1 empty=0 beat=0",
                 f[1].idx, f[1].last, f[1].empty, f[1].beat);
      end
      checks++;
      if (acc.size() != 2 || acc[1] != f[0].cyc || f[1].cyc != f[0].cyc + 1) begin
        failures++;
        $display("FAIL empty_handover: got accept cycle %0d beat cycles %0d/%0d, want accept on first beat and consecutive beats",
                 (acc.size() > 1) ? acc[1] : -1, f[0].cyc, f[1].cyc);
      end
    end
  endtask

  task automatic test_stall_ffff();
    int n;
    pend = '{16'hFFFF};
    build_expected();
    drive_stream(1);
    checks++;
    if (timed_out) begin failures++; $display("FAIL stall_timeout: got timeout, want completion"); end
    n = 0;
    foreach (obs[i]) begin
      if (obs[i].fired) begin
        if (n < exp_q.size()) begin
          checks++;
          if ({obs[i].idx, obs[i].last, obs[i].beat} !== {exp_q[n].idx, exp_q[n].last, exp_q[n].beat}) begin
            failures++;
            $display("FAIL stall_beat%0d: got idx=%0d last=%b beat=%0d, want idx=%0d last=%b beat=%0d",
                     n, obs[i].idx, obs[i].last, obs[i].beat, exp_q[n].idx, exp_q[n].last, exp_q[n].beat);
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 16) begin failures++; $display("FAIL stall_count: got %0d beats, want 16", n); end
    for (int i = 1; i < obs.size(); i++) begin
      if (!obs[i-1].fired && obs[i].cyc == obs[i-1].cyc + 1) begin
        checks++;
        if ({obs[i].idx, obs[i].last, obs[i].empty, obs[i].beat} !==
            {obs[i-1].idx, obs[i-1].last, obs[i-1].empty, obs[i-1].beat}) begin
          failures++;
          $display("FAIL stall_hold@%0d: got idx=%0d beat=%0d, want held idx=%0d beat=%0d",
                   obs[i].cyc, obs[i].idx, obs[i].beat, obs[i-1].idx, obs[i-1].beat);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t f[$];
    pend = '{16'h0300, 16'h0002};
    drive_stream(0);
    foreach (obs[i]) if (obs[i].fired) f.push_back(obs[i]);
    checks++;
    if (timed_out || f.size() != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d beats timeout=%0d, want 3 beats", f.size(), timed_out);
    end else begin
      checks++;
      if ({f[0].idx, f[1].idx, f[2].idx} !== {4'd6, 4'd7, 4'd14}) begin
        failures++;
        $display("FAIL b2b_idx: got %0d,%0d,%0d, want 6,7,14", f[0].idx, f[1].idx, f[2].idx);
      end
      checks++;
      if (f[1].cyc != f[0].cyc + 1 || f[2].cyc != f[1].cyc + 1) begin
        failures++;
        $display("FAIL b2b_gap: got cycles %0d,%0d,%0d, want consecutive", f[0].cyc, f[1].cyc, f[2].cyc);
      end
      checks++;
      if ({f[0].in_rdy, f[1].in_rdy} !== 2'b01) begin
        failures++;
        $display("FAIL b2b_ready: got in_ready %b/%b on idx6/idx7 beats, want 0/1", f[0].in_rdy, f[1].in_rdy);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t f[$];
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mask   = 16'hF000;
    #1;
    tick();
    in_valid = 1'b0;
    in_mask  = 16'hFFFF;
    tick();
    tick();
    #1;
    checks++;
    if ({out_valid, out_idx, out_beat} !== {1'b1, 4'd2, 5'd2}) begin
      failures++;
      $display("FAIL midrun_prereset: got valid=%b idx=%0d beat=%0d, want valid=1 idx=2 beat=2",
               out_valid, out_idx, out_beat);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL midrun_reset: got valid=%b ready=%b, want valid=0 ready=1", out_valid, in_ready);
    end
    pend = '{16'h0010};
    drive_stream(0);
    foreach (obs[i]) if (obs[i].fired) f.push_back(obs[i]);
    checks++;
    if (timed_out || f.size() != 1) begin
      failures++;
      $display("FAIL midrun_count: got %0d beats timeout=%0d, want 1 beat", f.size(), timed_out);
    end else begin
      checks++;
      if ({f[0].idx, f[0].last, f[0].empty, f[0].beat} !== {4'd11, 1'b1, 1'b0, 5'd0}) begin
        failures++;
        $display("FAIL midrun_beat: got idx=%0d last=%b empty=%b beat=%0d, want idx=11 last=1 empty=0 beat=0",
                 f[0].idx, f[0].last, f[0].empty, f[0].beat);
      end
    end
  endtask

  task automatic test_random();
    int n;
    logic [WIDTH-1:0] m;
    pend.delete();
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        2:       m = WIDTH'($urandom);
        default: m = WIDTH'($urandom) & WIDTH'($urandom);
      endcase
      pend.push_back(m);
    end
    build_expected();
    drive_stream(2);
    checks++;
    if (timed_out) begin failures++; $display("FAIL random_timeout: got timeout, want completion"); end
    n = 0;
    foreach (obs[i]) begin
      if (obs[i].fired) begin
        if (n < exp_q.size()) begin
          checks++;
          if ({obs[i].idx, obs[i].last, obs[i].empty, obs[i].beat} !==
              {exp_q[n].idx, exp_q[n].last, exp_q[n].empty, exp_q[n].beat}) begin
            failures++;
            $display("FAIL random_beat%0d: got idx=%0d last=%b empty=%b beat=%0d, want idx=%0d last=%b empty=%b beat=%0d",
                     n, obs[i].idx, obs[i].last, obs[i].empty, obs[i].beat,
                     exp_q[n].idx, exp_q[n].last, exp_q[n].empty, exp_q[n].beat);
          end
        end
        n++;
      end else if (i + 1 < obs.size() && obs[i+1].cyc == obs[i].cyc + 1) begin
        checks++;
        if ({obs[i+1].idx, obs[i+1].last, obs[i+1].empty, obs[i+1].beat} !==
            {obs[i].idx, obs[i].last, obs[i].empty, obs[i].beat}) begin
          failures++;
          $display("FAIL random_hold@%0d: got idx=%0d beat=%0d, want held idx=%0d beat=%0d",
                   obs[i+1].cyc, obs[i+1].idx, obs[i+1].beat, obs[i].idx, obs[i].beat);
        end
      end
    end
    checks++;
    if (n != exp_q.size()) begin
      failures++;
      $display("FAIL random_count: got %0d beats, want %0d", n, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_spaced();
    test_empty_then_one();
    test_stall_ffff();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
